// File: rtl/cached_memory_unit.sv
// ============================================================================
// cached_memory_unit : 2-way set-associative write-back data cache with LRU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cached_memory_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SET_BITS      = 2,
  parameter int BLOCK_BITS    = 1,
  parameter int WAYS          = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDRESS_WIDTH-1:0]              address,
  input  logic [DATA_WIDTH-1:0]                 write_data,
  input  logic [2:0]                            DATAMEMControl,
  input  logic                                  write_enable,
  input  logic                                  read_en,
  output logic [DATA_WIDTH-1:0]                 read_data,
  output logic                                  stall,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDRESS_WIDTH-2-BLOCK_BITS-1:0] mem_address,
  output logic [DATA_WIDTH*(2**BLOCK_BITS)-1:0] mem_wdata,
  input  logic [DATA_WIDTH*(2**BLOCK_BITS)-1:0] mem_rdata,
  input  logic                                  mem_ack
);

  localparam int LINE_W  = DATA_WIDTH * (2**BLOCK_BITS);
  localparam int SETS    = 2**SET_BITS;
  localparam int TAG_W   = ADDRESS_WIDTH - 2 - BLOCK_BITS - SET_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  // Address fields
  logic [1:0]            byte_off;
  logic [BLOCK_BITS-1:0] word_off;
  logic [SET_BITS-1:0]   index;
  logic [TAG_W-1:0]      req_tag;

  assign byte_off = address[1:0];
  assign word_off = address[2 +: BLOCK_BITS];
  assign index    = address[2+BLOCK_BITS +: SET_BITS];
  assign req_tag  = address[ADDRESS_WIDTH-1 -: TAG_W];

  // Cache state
  logic [1:0]                 state;
  logic [WAYS-1:0][SETS-1:0]  valid;
  logic [WAYS-1:0][SETS-1:0]  dirty;
  logic [SETS-1:0]            lru;
  logic                       vic_q;
  logic [TAG_W-1:0]           tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]          data_mem [WAYS][SETS];

  // Lookup
  logic [WAYS-1:0] way_hit;
  logic            access;
  logic            hit;
  logic            hit_way;

  for (genvar w = 0; w < WAYS; w++) begin : g_way_hit
    assign way_hit[w] = valid[w][index] && (tag_mem[w][index] == req_tag);
  end

  assign access  = read_en | write_enable;
  assign hit     = rst_n && (state == IDLE) && access && (|way_hit);
  assign hit_way = way_hit[1];

  logic [LINE_W-1:0]     hit_line;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign hit_line = data_mem[hit_way][index];
  assign hit_word = hit_line[int'(word_off)*DATA_WIDTH +: DATA_WIDTH];
  assign byte_sel = hit_word[int'(byte_off)*8 +: 8];
  assign half_sel = hit_word[int'(byte_off[1])*16 +: 16];

  // Load extraction
  logic [DATA_WIDTH-1:0] load_val;

  always_comb begin
    load_val = hit_word;
    case (DATAMEMControl)
      3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_val = hit_word;
    endcase
  end

  // A store on the same cycle as a load wins, so load data is only shown for pure loads
  assign read_data = (hit && !write_enable) ? load_val : '0;

  // Store merge into the hit line
  logic [DATA_WIDTH-1:0] merged_word;
  logic [LINE_W-1:0]     new_line;

  always_comb begin
    merged_word = hit_word;
    case (DATAMEMControl[1:0])
      2'b00:   merged_word[int'(byte_off)*8 +: 8]     = write_data[7:0];
      2'b01:   merged_word[int'(byte_off[1])*16 +: 16] = write_data[15:0];
      default: merged_word = write_data;
    endcase
    new_line = hit_line;
    new_line[int'(word_off)*DATA_WIDTH +: DATA_WIDTH] = merged_word;
  end

  // Victim selection: first invalid way, otherwise the LRU way
  logic victim_way;
  logic victim_dirty;

  always_comb begin
    if (!valid[0][index]) begin
      victim_way = 1'b0;
    end else if (!valid[1][index]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru[index];
    end
    victim_dirty = valid[victim_way][index] && dirty[victim_way][index];
  end

  // Control state, valid/dirty/LRU bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      lru   <= '0;
      vic_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (|way_hit) begin
              lru[index] <= ~hit_way;
              if (write_enable) begin
                dirty[hit_way][index] <= 1'b1;
              end
            end else begin
              vic_q <= victim_way;
              state <= victim_dirty ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            state <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid[vic_q][index] <= 1'b1;
            dirty[vic_q][index] <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (hit && write_enable) begin
        data_mem[hit_way][index] <= new_line;
      end
      if ((state == REFILL) && mem_ack) begin
        data_mem[vic_q][index] <= mem_rdata;
        tag_mem[vic_q][index]  <= req_tag;
      end
    end
  end

  // Memory-side interface
  assign stall   = rst_n && ((state != IDLE) || (access && !(|way_hit)));
  assign mem_req = (state == WRITEBACK) || (state == REFILL);
  assign mem_we  = (state == WRITEBACK);

  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    if (state == WRITEBACK) begin
      mem_address = {tag_mem[vic_q][index], index};
      mem_wdata   = data_mem[vic_q][index];
    end else if (state == REFILL) begin
      mem_address = {req_tag, index};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cached_memory_unit.sv
// ============================================================================
// tb_cached_memory_unit : directed self-checking bench for cached_memory_unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cached_memory_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  DATAMEMControl;
  logic        write_enable;
  logic        read_en;
  logic [31:0] read_data;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [28:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack   = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cached_memory_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .write_data     (write_data),
    .DATAMEMControl (DATAMEMControl),
    .write_enable   (write_enable),
    .read_en        (read_en),
    .read_data      (read_data),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  // Backing-memory responder with programmable ack delay
  logic [63:0] mem_model [int unsigned];
  int          ack_delay = 0;
  bit          hold_ack  = 0;
  int          wait_cnt  = 0;
  int          wb_cnt    = 0;
  int          ref_cnt   = 0;
  int          unstable_cnt = 0;
  logic [28:0] last_wb_addr  = '0;
  logic [28:0] last_ref_addr = '0;
  logic [63:0] last_wb_data  = '0;
  bit          prev_req = 0;
  bit          prev_ack = 0;
  logic [28:0] cap_addr  = '0;
  logic        cap_we    = 1'b0;
  logic [63:0] cap_wdata = '0;

  always @(negedge clk) begin
    if (mem_req && (!prev_req || prev_ack)) begin
      cap_addr  = mem_address;
      cap_we    = mem_we;
      cap_wdata = mem_wdata;
    end else if (mem_req && ((mem_address !== cap_addr) || (mem_we !== cap_we) ||
                             (mem_wdata !== cap_wdata))) begin
      unstable_cnt++;
    end
    prev_ack = mem_ack;
    prev_req = mem_req;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req && !hold_ack) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[32'(mem_address)] = mem_wdata;
          wb_cnt++;
          last_wb_addr = mem_address;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem_model.exists(32'(mem_address)) ? mem_model[32'(mem_address)]
                                                         : 64'hDEAD_BEEF_DEAD_BEEF;
          ref_cnt++;
          last_ref_addr = mem_address;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One CPU access: hold request until stall drops, return load data and stalled cycles
  task automatic access(input string nm, input logic [31:0] a, input logic [2:0] ctl,
                        input logic we, input logic re, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    bit done = 0;
    @(posedge clk); #1;
    address = a; DATAMEMControl = ctl; write_enable = we; read_en = re; write_data = wd;
    cyc = 0;
    rd  = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (stall) cyc++;
      else begin
        rd   = read_data;
        done = 1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: stall=%b after 60 cycles, required 0", nm, stall);
    end
    @(posedge clk); #1;
    write_enable = 1'b0;
    read_en      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address = 32'h40; write_data = '0; DATAMEMControl = 3'b010;
    write_enable = 1'b0; read_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b required 0", stall); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL rst_read_data: got %h required 0", read_data); end
    @(posedge clk); #1;
    read_en = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL post_rst_stall: got %b required 0", stall); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL post_rst_mem_req: got %b required 0", mem_req); end
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int cyc; int r0, w0;
    mem_model[32'h08] = {32'h2222_2222, 32'h1111_1111};
    r0 = ref_cnt; w0 = wb_cnt;
    access("cold_lw", 32'h40, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h1111_1111) begin miscompares++; $display("FAIL cold_lw_data: got %h required 11111111", rd); end
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL cold_lw_stall_cycles: got %0d required 2", cyc); end
    vectors++; if (ref_cnt - r0 !== 1) begin miscompares++; $display("FAIL cold_lw_refills: got %0d required 1", ref_cnt - r0); end
    vectors++; if (last_ref_addr !== 29'h08) begin miscompares++; $display("FAIL cold_lw_mem_address: got %h required 08", last_ref_addr); end
    vectors++; if (wb_cnt - w0 !== 0) begin miscompares++; $display("FAIL cold_lw_writebacks: got %0d required 0", wb_cnt - w0); end
  endtask

  task automatic test_store_merge();
    logic [31:0] rd; int cyc; int r0, w0;
    r0 = ref_cnt; w0 = wb_cnt;
    access("sb", 32'h41, 3'b000, 1'b1, 1'b0, 32'h0000_0080, rd, cyc);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL sb_hit_stall: got %0d required 0", cyc); end
    access("lb", 32'h41, 3'b000, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_sign: got %h required ffffff80", rd); end
    access("lbu", 32'h41, 3'b100, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_zero: got %h required 00000080", rd); end
    access("lw", 32'h40, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h1111_8011) begin miscompares++; $display("FAIL lw_merged: got %h required 11118011", rd); end
    access("lw_unaligned", 32'h43, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h1111_8011) begin miscompares++; $display("FAIL lw_ignores_offset: got %h required 11118011", rd); end
    access("sh", 32'h46, 3'b001, 1'b1, 1'b0, 32'h5555_BEEF, rd, cyc);
    access("lh", 32'h46, 3'b001, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hFFFF_BEEF) begin miscompares++; $display("FAIL lh_sign: got %h required ffffbeef", rd); end
    access("lhu", 32'h46, 3'b101, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lhu_zero: got %h required 0000beef", rd); end
    access("lw_word1", 32'h44, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hBEEF_2222) begin miscompares++; $display("FAIL lw_half_merged: got %h required beef2222", rd); end
    vectors++; if ((ref_cnt - r0) + (wb_cnt - w0) !== 0) begin miscompares++; $display("FAIL hit_no_mem_req: got %0d transactions required 0", (ref_cnt - r0) + (wb_cnt - w0)); end
    @(negedge clk);
    vectors++; if (read_data !== 32'h0 || stall !== 1'b0) begin miscompares++; $display("FAIL idle_outputs: read_data %h stall %b required 0 0", read_data, stall); end
  endtask

  task automatic test_writeback();
    logic [31:0] rd; int cyc; int w0;
    mem_model[32'h10] = {32'h4444_4444, 32'h3333_3333};
    mem_model[32'h18] = {32'h6666_6666, 32'h5555_5555};
    w0 = wb_cnt;
    access("fill_way1", 32'h80, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h3333_3333) begin miscompares++; $display("FAIL fill_way1_data: got %h required 33333333", rd); end
    vectors++; if (wb_cnt - w0 !== 0) begin miscompares++; $display("FAIL fill_invalid_no_wb: got %0d required 0", wb_cnt - w0); end
    access("evict_dirty", 32'hC4, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h6666_6666) begin miscompares++; $display("FAIL evict_data: got %h required 66666666", rd); end
    vectors++; if (wb_cnt - w0 !== 1) begin miscompares++; $display("FAIL evict_wb_count: got %0d required 1", wb_cnt - w0); end
    vectors++; if (last_wb_addr !== 29'h08) begin miscompares++; $display("FAIL evict_wb_address: got %h required 08", last_wb_addr); end
    vectors++; if (last_wb_data !== 64'hBEEF_2222_1111_8011) begin miscompares++; $display("FAIL evict_wb_data: got %h required beef222211118011", last_wb_data); end
    vectors++; if (last_ref_addr !== 29'h18) begin miscompares++; $display("FAIL evict_refill_address: got %h required 18", last_ref_addr); end
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL evict_stall_cycles: got %0d required 4", cyc); end
    w0 = wb_cnt;
    access("reload_written_back", 32'h44, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hBEEF_2222) begin miscompares++; $display("FAIL reload_data: got %h required beef2222", rd); end
    vectors++; if (wb_cnt - w0 !== 0) begin miscompares++; $display("FAIL reload_clean_no_wb: got %0d required 0", wb_cnt - w0); end
  endtask

  task automatic test_lru();
    logic [31:0] rd; int cyc; int w0;
    mem_model[32'h21] = {32'hAAAA_0001, 32'hAAAA_0000};
    mem_model[32'h25] = {32'hBBBB_0001, 32'hBBBB_0000};
    mem_model[32'h29] = {32'hCCCC_0001, 32'hCCCC_0000};
    access("fill_a", 32'h108, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    access("fill_b", 32'h128, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hBBBB_0000) begin miscompares++; $display("FAIL lru_fill_b: got %h required bbbb0000", rd); end
    access("hit_a", 32'h108, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL lru_hit_a_stall: got %0d required 0", cyc); end
    w0 = wb_cnt;
    access("miss_c", 32'h148, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'hCCCC_0000) begin miscompares++; $display("FAIL lru_miss_c_data: got %h required cccc0000", rd); end
    vectors++; if (wb_cnt - w0 !== 0) begin miscompares++; $display("FAIL lru_clean_no_wb: got %0d required 0", wb_cnt - w0); end
    access("a_kept", 32'h108, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (cyc !== 0 || rd !== 32'hAAAA_0000) begin miscompares++; $display("FAIL lru_a_kept: stall %0d data %h required 0 aaaa0000", cyc, rd); end
    access("sw_and_lw", 32'h108, 3'b010, 1'b1, 1'b1, 32'h1234_5678, rd, cyc);
    access("lw_after_sw", 32'h108, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL store_priority: got %h required 12345678", rd); end
    access("b_evicted", 32'h128, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL lru_b_evicted_stall: got %0d required 2", cyc); end
  endtask

  task automatic test_ack_delay();
    logic [31:0] rd; int cyc; int u0;
    mem_model[32'h0E] = {32'h7777_7777, 32'h7070_7070};
    mem_model[32'h07] = {32'h3939_3939, 32'h3838_3838};
    ack_delay = 5;
    u0 = unstable_cnt;
    access("slow_ack", 32'h74, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h7777_7777) begin miscompares++; $display("FAIL slow_ack_data: got %h required 77777777", rd); end
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL slow_ack_stall_cycles: got %0d required 7", cyc); end
    vectors++; if (unstable_cnt - u0 !== 0) begin miscompares++; $display("FAIL mem_req_fields_stable: got %0d changes required 0", unstable_cnt - u0); end
    ack_delay = 0;
    access("entry_ack", 32'h38, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h3838_3838 || cyc !== 2) begin miscompares++; $display("FAIL entry_ack: data %h stall %0d required 38383838 2", rd, cyc); end
  endtask

  task automatic test_reset_refill();
    logic [31:0] rd; int cyc; int r0;
    mem_model[32'h0B] = {32'h5B5B_5B5B, 32'h5A5A_5A5A};
    hold_ack = 1;
    @(posedge clk); #1;
    address = 32'h58; DATAMEMControl = 3'b010; read_en = 1'b1; write_enable = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL held_refill_req: req %b we %b required 1 0", mem_req, mem_we); end
    vectors++; if (mem_address !== 29'h0B) begin miscompares++; $display("FAIL held_refill_address: got %h required 0b", mem_address); end
    @(posedge clk); #1;
    rst_n = 1'b0; read_en = 1'b0;
    @(posedge clk); #1;
    hold_ack = 0;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL abort_mem_req: got %b required 0", mem_req); end
    vectors++; if (stall !== 1'b0 || read_data !== 32'h0) begin miscompares++; $display("FAIL abort_outputs: stall %b read_data %h required 0 0", stall, read_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0 = ref_cnt;
    access("relw_after_abort", 32'h58, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (rd !== 32'h5A5A_5A5A || cyc !== 2) begin miscompares++; $display("FAIL relw_after_abort: data %h stall %0d required 5a5a5a5a 2", rd, cyc); end
    vectors++; if (ref_cnt - r0 !== 1) begin miscompares++; $display("FAIL relw_refills: got %0d required 1", ref_cnt - r0); end
    access("invalidated", 32'h38, 3'b010, 1'b0, 1'b1, 32'h0, rd, cyc);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL reset_invalidates: got %0d stall cycles required 2", cyc); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_merge();
    test_writeback();
    test_lru();
    test_ack_delay();
    test_reset_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire

// File: doc/cached_memory_unit.md
CACHED_MEMORY_UNIT -- requirements
Module: cached_memory_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be 32.
REQ-002 Parameter ADDRESS_WIDTH, default 32: byte-address width.
REQ-003 Parameter SET_BITS, default 2: log2 of the number of sets.
REQ-004 Parameter BLOCK_BITS, default 1: log2 of words per line; LINE_W = DATA_WIDTH*2**BLOCK_BITS.
REQ-005 Parameter WAYS, default 2: associativity, fixed at 2, with 1 LRU bit per set.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 address  in  ADDRESS_WIDTH  byte address of the CPU access.
REQ-009 write_data  in  DATA_WIDTH  store data, right-aligned.
REQ-010 DATAMEMControl  in  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-011 write_enable  in  1  store request.
REQ-012 read_en  in  1  load request.
REQ-013 read_data  out  DATA_WIDTH  load result, sign- or zero-extended.
REQ-014 stall  out  1  access not complete; CPU holds all request inputs stable while high.
REQ-015 mem_req  out  1  backing-memory request, held until mem_ack.
REQ-016 mem_we  out  1  1 = line write-back, 0 = line refill.
REQ-017 mem_address  out  ADDRESS_WIDTH-2-BLOCK_BITS  line address.
REQ-018 mem_wdata  out  LINE_W  victim line data.
REQ-019 mem_rdata  in  LINE_W  refill data, valid in the mem_ack cycle.
REQ-020 mem_ack  in  1  one-cycle completion pulse; ignored when mem_req=0.

Function
REQ-021 Address split: [1:0] byte offset, then BLOCK_BITS word offset, then SET_BITS index, remaining bits tag.
REQ-022 Per way and set, the block SHALL hold valid, dirty, tag and line data.
REQ-023 FSM states: IDLE, WRITEBACK, REFILL.
REQ-024 IDLE hit (read_en or write_enable, valid and tag match): stall=0 combinationally; load data on read_data in the same cycle; store written at the next edge, dirty set, LRU pointed at the other way.
REQ-025 Store with write_enable=1 takes priority when read_en is also 1; with both at 0, no state change and stall=0.
REQ-026 Store merge: SB writes byte address[1:0]; SH writes halfword address[1]; SW writes the whole word; other bytes are preserved.
REQ-027 Load extract: LB/LH sign-extend; LBU/LHU zero-extend; LW ignores address[1:0].
REQ-028 Victim choice on a miss: first invalid way (way 0 before way 1), else the LRU way.
REQ-029 IDLE miss: stall=1 in the same cycle; next state is WRITEBACK if the victim is valid and dirty, else REFILL.
REQ-030 WRITEBACK: mem_req=1, mem_we=1, mem_address={victim tag,index}, mem_wdata=victim line; on mem_ack, go to REFILL.
REQ-031 REFILL: mem_req=1, mem_we=0, mem_address={req tag,index}; on mem_ack, write mem_rdata to the line with valid=1, dirty=0 and the new tag, then go to IDLE.
REQ-032 After REFILL the access re-evaluates in IDLE as a hit, so miss latency = ack cycles + 1, and stall stays high until that hit cycle.
REQ-033 mem_req SHALL stay asserted with constant mem_address, mem_we and mem_wdata from state entry through the mem_ack cycle.
REQ-034 mem_ack in the same cycle as state entry is legal and SHALL be honoured.
REQ-035 read_data SHALL be 0 when there is no hit.

Reset
REQ-036 rst_n=0 at an edge: FSM to IDLE, all valid, dirty and LRU bits cleared; line data is not reset.
REQ-037 During and after reset: stall=0 (no request pending), mem_req=0, mem_we=0, read_data=0.
REQ-038 Reset mid-WRITEBACK or mid-REFILL aborts the transaction: mem_req drops the cycle after the reset edge, dirty data is discarded, and a late mem_ack is ignored.

Verification
REQ-039 Cold LW at 0x40 with memory line {0x22222222,0x11111111}: stall=1, one REFILL with mem_address=0x08; after ack, read_data=0x11111111 and stall=0 one cycle later.
REQ-040 SB 0x80 to 0x41 after the line is filled, then LB 0x41 -> 0xFFFFFF80, LBU 0x41 -> 0x00000080, LW 0x40 -> 0x11118011; no mem_req issued.
REQ-041 Three tags mapping to set 0, the first dirtied: the third access causes WRITEBACK of the first line (mem_we=1, correct mem_wdata), then REFILL.
REQ-042 LRU: fill ways with tags A and B, hit A, miss with tag C -> B evicted with no write-back (clean).
REQ-043 Delay mem_ack 5 cycles -> stall held and mem_req fields stable; ack in the entry cycle -> done in 2 cycles.
REQ-044 Assert rst_n=0 during REFILL -> mem_req=0 next cycle, and the next LW to the same address misses again.
